uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

- Sequences one `uart_rx` instance.
- Watches the synchronized serial line for a start edge and issues a one-cycle `rx_start`.
- Supervises the frame, with a timeout, until `rx_done` or an error flag.
- Buffers good bytes in a FIFO drained over a valid/ready stream, and keeps error statistics.
- Sits between `uart_rx` and the host/bus interface; the baud generator `tick` is shared with `uart_rx`.

## Interface
- `DATA_WD`, 8, receiver data width.
- `OVERSAMPLING_RATE`, 16, ticks per bit; must match `uart_rx`.
- `TIMEOUT_TICKS`, 192, max ticks from `rx_start` to `rx_done`/error before abort.
- `IDLE_TICKS`, 16, consecutive high-line ticks required to leave RECOVER.
- `FIFO_DEPTH`, 8, byte buffer depth; power of two, ≥2.
- `CNT_WD`, 16, error counter width.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: 0 blocks new frames; a frame in progress completes.
- `rx_line` in 1: raw serial pin (same wire as `uart_rx.rx`).
- `tick` in 1: baud×oversampling pulse.
- `rx_start` out 1: one-cycle start request to `uart_rx`.
- `rx_done` in 1: from `uart_rx`.
- `rx_busy` in 1: from `uart_rx`.
- `parity_error_flag` in 1: from `uart_rx`.
- `framing_error_flag` in 1: from `uart_rx`.
- `rx_dout` in `DATA_WD`: from `uart_rx`.
- `m_data` out `DATA_WD`: FIFO head.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: host pop.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: occupancy.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `frame_err_cnt` out `CNT_WD`: framing errors, saturating.
- `parity_err_cnt` out `CNT_WD`: parity errors, saturating.
- `timeout_cnt` out `CNT_WD`: timeouts, saturating.
- `clear_stats` in 1: synchronous clear of counters and `overrun`.

## Operation
`rx_line` passes through a 2-flop synchronizer (reset value 1) to give `line_s`. A start edge is `line_s_d==1 && line_s==0`.

FSM states:
- **IDLE**: on start edge && `enable` → ARM.
- **ARM**: assert `rx_start` for exactly this cycle; clear tick timer → WAIT.
- **WAIT**: count ticks.
  - Rising edge of `rx_done` → STORE.
  - Error flag (framing has priority over parity) → increment matching counter → RECOVER.
  - Timer reaches `TIMEOUT_TICKS` → increment `timeout_cnt` → RECOVER.
- **STORE**: push `rx_dout` if there is room, else drop it and set `overrun` → IDLE.
- **RECOVER**: count ticks while `line_s==1`; reset the count whenever `line_s==0`. After `IDLE_TICKS` → IDLE.

FIFO rules:
- Push has room when `!full || (m_valid && m_ready)`; a pop in the same cycle frees a slot.
- Pop when `m_valid && m_ready`.
- First-word fall-through: `m_data` is valid together with `m_valid`.
- Pointers wrap modulo `FIFO_DEPTH`.

Counters:
- Saturate at all-ones.
- `clear_stats` wins over a same-cycle increment (result 0).

`enable` deasserting mid-frame has no effect until the FSM returns to IDLE.

## Timing
Reset values:
- FSM in IDLE; synchronizer flops 1.
- `rx_start`=0, `m_valid`=0, `m_data`=0, `fifo_level`=0, `overrun`=0, all counters 0.

Latencies:
- Pin to `line_s`: 2 cycles.
- Edge detected in cycle N (FSM in IDLE) → ARM in N+1 → `rx_start` high in N+1 only.
- `rx_done` rising edge in cycle M → STORE in M+1 → `m_valid` high in M+2 (empty FIFO).
- Error flag sampled in WAIT in cycle E → counter updated in E+1.

Reset behaviour:
- `rst_n` low mid-frame returns to IDLE immediately, with no counter update and the FIFO emptied.
- An `rx_done` level held from a previous frame never re-triggers; only a rising edge counts.

## Structure
- Package `uart_pkg`: FSM state encoding (one-hot, 5 states), default parameter constants, counter width.
- Sub-module `uart_sync_fifo` (params `WIDTH`, `DEPTH`; ports push/pop/full/empty/level), instanced once.
- The synchronizer and counters stay inline.

## Test plan
- **Single good frame**: 0xA5 on the line → one `rx_start` pulse; 2 cycles after `rx_done` rises, `m_valid`=1 and `m_data`=0xA5; `fifo_level`=1.
- **FIFO overrun**: 9 frames with `m_ready`=0 and `FIFO_DEPTH`=8 → `fifo_level`=8, 9th byte dropped, `overrun`=1; `clear_stats` → `overrun`=0 and FIFO kept.
- **Errors**: one framing error and one parity error → `frame_err_cnt`=1, `parity_err_cnt`=1, nothing pushed; no new `rx_start` until the line has been high for 16 ticks.
- **Timeout**: `rx_done` never asserted → RECOVER after 192 ticks, `timeout_cnt`=1.
- **Full FIFO with same-cycle pop**: full FIFO, `m_ready`=1 in the STORE cycle → byte accepted, `fifo_level` stays 8, `overrun`=0.
- **Reset mid-frame**: `rst_n` pulsed low during WAIT → all outputs at reset values; the next good frame 0x3C is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: default parameters,
// one-hot FSM encoding and a small sizing helper.
package uart_pkg;

  localparam int unsigned DATA_WD_DEF           = 8;
  localparam int unsigned OVERSAMPLING_RATE_DEF = 16;
  localparam int unsigned TIMEOUT_TICKS_DEF     = 192;
  localparam int unsigned IDLE_TICKS_DEF        = 16;
  localparam int unsigned FIFO_DEPTH_DEF        = 8;
  localparam int unsigned CNT_WD_DEF            = 16;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ARM     = 5'b00010,
    ST_WAIT    = 5'b00100,
    ST_STORE   = 5'b01000,
    ST_RECOVER = 5'b10000
  } ctrl_state_e;

  // Largest of three tick limits; sizes the shared tick timer
  function automatic int unsigned max3_u(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Ports: push/din write side, pop/dout read side (dout valid while !empty),
// full/empty flags and level occupancy. A pop frees a slot for a same-cycle
// push when full. DEPTH must be a power of two >= 2.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  // Head word is shown as zero while empty so the output is clean after reset
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for one uart_rx instance.
// Detects a start edge on the synchronized line, pulses rx_start, supervises
// the frame with a tick timeout, buffers good bytes in a FIFO drained over
// m_data/m_valid/m_ready, and keeps saturating error statistics.
// Ports: clk, rst_n, enable, rx_line, tick; rx_start to uart_rx;
// rx_done/rx_busy/parity_error_flag/framing_error_flag/rx_dout from uart_rx;
// m_data/m_valid/m_ready stream, fifo_level, overrun, error counters,
// clear_stats.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WD           = DATA_WD_DEF,
  parameter int unsigned OVERSAMPLING_RATE = OVERSAMPLING_RATE_DEF,
  parameter int unsigned TIMEOUT_TICKS     = TIMEOUT_TICKS_DEF,
  parameter int unsigned IDLE_TICKS        = IDLE_TICKS_DEF,
  parameter int unsigned FIFO_DEPTH        = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_WD            = CNT_WD_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          rx_line,
  input  logic                          tick,
  output logic                          rx_start,
  input  logic                          rx_done,
  input  logic                          rx_busy,
  input  logic                          parity_error_flag,
  input  logic                          framing_error_flag,
  input  logic [DATA_WD-1:0]            rx_dout,
  output logic [DATA_WD-1:0]            m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [CNT_WD-1:0]             frame_err_cnt,
  output logic [CNT_WD-1:0]             parity_err_cnt,
  output logic [CNT_WD-1:0]             timeout_cnt,
  input  logic                          clear_stats
);

  // Timer covers the frame timeout, the recovery idle window and a bit period
  localparam int unsigned TMR_WD =
    $clog2(max3_u(TIMEOUT_TICKS, IDLE_TICKS, OVERSAMPLING_RATE) + 1);

  ctrl_state_e       state;
  logic [TMR_WD-1:0] timer;
  logic              sync1;
  logic              line_s;
  logic              line_s_d;
  logic              rx_done_d;

  logic              start_edge;
  logic              done_rise;
  logic              err_any;
  logic              in_wait;
  logic              frame_inc;
  logic              parity_inc;
  logic              timeout_inc;
  logic              has_room;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_busy;

  // Busy is informational only; sequencing relies on done and error flags
  assign unused_busy = rx_busy;

  // Two-flop synchronizer plus edge-detect history; idle line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      line_s    <= 1'b1;
      line_s_d  <= 1'b1;
      rx_done_d <= 1'b0;
    end else begin
      sync1     <= rx_line;
      line_s    <= sync1;
      line_s_d  <= line_s;
      rx_done_d <= rx_done;
    end
  end

  assign start_edge = line_s_d && !line_s;
  assign done_rise  = rx_done && !rx_done_d;
  assign err_any    = framing_error_flag || parity_error_flag;
  assign in_wait    = (state == ST_WAIT);

  // Error classification: framing outranks parity, any error outranks done
  assign frame_inc   = in_wait && framing_error_flag;
  assign parity_inc  = in_wait && !framing_error_flag && parity_error_flag;
  assign timeout_inc = in_wait && !err_any && !done_rise && tick &&
                       (timer == TMR_WD'(TIMEOUT_TICKS - 1));

  // A same-cycle pop frees a slot for the byte being stored
  assign has_room  = !fifo_full || (m_valid && m_ready);
  assign fifo_push = (state == ST_STORE) && has_room;

  // Frame sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      rx_start <= 1'b0;
    end else begin
      rx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge && enable) begin
            state    <= ST_ARM;
            rx_start <= 1'b1;
          end
        end
        ST_ARM: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (err_any) begin
            timer <= '0;
            state <= ST_RECOVER;
          end else if (done_rise) begin
            state <= ST_STORE;
          end else if (timeout_inc) begin
            timer <= '0;
            state <= ST_RECOVER;
          end else if (tick) begin
            timer <= timer + TMR_WD'(1);
          end
        end
        ST_STORE: begin
          state <= ST_IDLE;
        end
        ST_RECOVER: begin
          // Line must stay high for a full idle window before rearming
          if (!line_s) begin
            timer <= '0;
          end else if (tick) begin
            if (timer == TMR_WD'(IDLE_TICKS - 1)) begin
              timer <= '0;
              state <= ST_IDLE;
            end else begin
              timer <= timer + TMR_WD'(1);
            end
          end
        end
        default: begin
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun and saturating error counters; clear wins over updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun        <= 1'b0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      timeout_cnt    <= '0;
    end else if (clear_stats) begin
      overrun        <= 1'b0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      timeout_cnt    <= '0;
    end else begin
      if ((state == ST_STORE) && !has_room)
        overrun <= 1'b1;
      if (frame_inc && (frame_err_cnt != '1))
        frame_err_cnt <= frame_err_cnt + CNT_WD'(1);
      if (parity_inc && (parity_err_cnt != '1))
        parity_err_cnt <= parity_err_cnt + CNT_WD'(1);
      if (timeout_inc && (timeout_cnt != '1))
        timeout_cnt <= timeout_cnt + CNT_WD'(1);
    end
  end

  assign m_valid = !fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (rx_dout),
    .pop   (m_ready),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; the bench plays the role of uart_rx and
// the host, with a tick every 4 clocks.
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        rx_line;
  logic        tick;
  logic        rx_start;
  logic        rx_done;
  logic        rx_busy;
  logic        parity_error_flag;
  logic        framing_error_flag;
  logic [7:0]  rx_dout;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic [15:0] frame_err_cnt;
  logic [15:0] parity_err_cnt;
  logic [15:0] timeout_cnt;
  logic        clear_stats;

  int n_vec;
  int n_err;
  int tcnt;

  uart_rx_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .rx_line            (rx_line),
    .tick               (tick),
    .rx_start           (rx_start),
    .rx_done            (rx_done),
    .rx_busy            (rx_busy),
    .parity_error_flag  (parity_error_flag),
    .framing_error_flag (framing_error_flag),
    .rx_dout            (rx_dout),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .fifo_level         (fifo_level),
    .overrun            (overrun),
    .frame_err_cnt      (frame_err_cnt),
    .parity_err_cnt     (parity_err_cnt),
    .timeout_cnt        (timeout_cnt),
    .clear_stats        (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one pulse every 4 clocks
  initial begin
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 1;
      tick = ((tcnt % 4) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop the line and expect a single rx_start pulse within a bounded window
  task automatic start_frame(input string tag);
    bit seen;
    seen = 1'b0;
    rx_line = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1);
      if (rx_start === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_start"}, 32'(seen), 32'd1);
    step(1);
    check_eq({tag, "_start_1cyc"}, 32'(rx_start), 32'd0);
  endtask

  task automatic expect_no_start(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (rx_start === 1'b1) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  // uart_rx reports a completed byte; line returns to idle high
  task automatic deliver(input logic [7:0] d);
    rx_dout = d;
    rx_line = 1'b1;
    rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
    step(3);
  endtask

  initial begin
    logic [7:0] expv;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    rx_line = 1'b1;
    rx_done = 1'b0;
    rx_busy = 1'b0;
    parity_error_flag = 1'b0;
    framing_error_flag = 1'b0;
    rx_dout = 8'h00;
    m_ready = 1'b0;
    clear_stats = 1'b0;
    step(3);

    // Reset values
    check_eq("rst_rx_start", 32'(rx_start), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_cnts", 32'(frame_err_cnt | parity_err_cnt | timeout_cnt), 32'd0);
    rst_n = 1'b1;
    step(4);

    // Single good frame: m_valid appears two cycles after rx_done rises
    start_frame("good");
    step(3);
    rx_dout = 8'hA5;
    rx_line = 1'b1;
    rx_done = 1'b1;
    step(1);
    check_eq("good_store_not_yet", 32'(m_valid), 32'd0);
    step(1);
    check_eq("good_m_valid", 32'(m_valid), 32'd1);
    check_eq("good_m_data", 32'(m_data), 32'hA5);
    check_eq("good_level", 32'(fifo_level), 32'd1);
    // rx_done stays high: the next frame must not store on the held level
    step(2);
    start_frame("held");
    step(5);
    check_eq("held_done_no_retrigger", 32'(fifo_level), 32'd1);
    rx_done = 1'b0;
    rx_line = 1'b1;
    step(1);
    rx_dout = 8'h5A;
    rx_done = 1'b1;
    step(2);
    rx_done = 1'b0;
    check_eq("held_second_byte", 32'(fifo_level), 32'd2);
    m_ready = 1'b1;
    check_eq("drain_a5", 32'(m_data), 32'hA5);
    step(1);
    check_eq("drain_5a", 32'(m_data), 32'h5A);
    step(1);
    m_ready = 1'b0;
    check_eq("drain_empty", 32'(m_valid), 32'd0);
    step(3);

    // Framing error, then recovery that restarts on any low glitch
    start_frame("ferr");
    step(3);
    framing_error_flag = 1'b1;
    step(1);
    framing_error_flag = 1'b0;
    check_eq("ferr_cnt", 32'(frame_err_cnt), 32'd1);
    check_eq("ferr_parity_cnt", 32'(parity_err_cnt), 32'd0);
    step(4);
    rx_line = 1'b1;
    step(32);
    rx_line = 1'b0;
    step(4);
    rx_line = 1'b1;
    step(40);
    rx_line = 1'b0;
    expect_no_start("recover_no_start", 12);
    rx_line = 1'b1;
    step(80);

    // Parity error
    start_frame("perr");
    step(3);
    parity_error_flag = 1'b1;
    step(1);
    parity_error_flag = 1'b0;
    check_eq("perr_cnt", 32'(parity_err_cnt), 32'd1);
    check_eq("perr_frame_cnt", 32'(frame_err_cnt), 32'd1);
    rx_line = 1'b1;
    step(80);

    // Both flags: framing takes priority
    start_frame("both");
    step(3);
    parity_error_flag = 1'b1;
    framing_error_flag = 1'b1;
    step(1);
    parity_error_flag = 1'b0;
    framing_error_flag = 1'b0;
    check_eq("both_frame_cnt", 32'(frame_err_cnt), 32'd2);
    check_eq("both_parity_cnt", 32'(parity_err_cnt), 32'd1);
    check_eq("err_nothing_pushed", 32'(fifo_level), 32'd0);
    rx_line = 1'b1;
    step(80);

    // Timeout after 192 ticks with no rx_done
    start_frame("tmo");
    step(760);
    check_eq("tmo_not_yet", 32'(timeout_cnt), 32'd0);
    step(60);
    check_eq("tmo_cnt", 32'(timeout_cnt), 32'd1);
    rx_line = 1'b1;
    step(80);

    // Overrun: nine bytes into an eight-deep FIFO with no pops
    for (int i = 0; i < 9; i++) begin
      start_frame("ovr");
      step(2);
      deliver(8'h10 + 8'(i));
    end
    check_eq("ovr_level", 32'(fifo_level), 32'd8);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_head", 32'(m_data), 32'h10);
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
    check_eq("clr_overrun", 32'(overrun), 32'd0);
    check_eq("clr_level_kept", 32'(fifo_level), 32'd8);
    check_eq("clr_frame_cnt", 32'(frame_err_cnt), 32'd0);
    check_eq("clr_timeout_cnt", 32'(timeout_cnt), 32'd0);

    // Full FIFO with a pop in the STORE cycle accepts the byte
    start_frame("fpop");
    step(2);
    rx_dout = 8'h55;
    rx_line = 1'b1;
    rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check_eq("fpop_level", 32'(fifo_level), 32'd8);
    check_eq("fpop_overrun", 32'(overrun), 32'd0);
    check_eq("fpop_head", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expv = (i < 7) ? (8'h11 + 8'(i)) : 8'h55;
      check_eq("fpop_drain", 32'(m_data), 32'(expv));
      step(1);
    end
    m_ready = 1'b0;
    check_eq("fpop_empty", 32'(m_valid), 32'd0);
    step(3);

    // Reset during WAIT with a stored byte and a nonzero counter
    start_frame("pre");
    step(2);
    deliver(8'h77);
    start_frame("pre_err");
    step(3);
    framing_error_flag = 1'b1;
    step(1);
    framing_error_flag = 1'b0;
    rx_line = 1'b1;
    step(80);
    check_eq("pre_rst_level", 32'(fifo_level), 32'd1);
    start_frame("mid");
    step(5);
    rst_n = 1'b0;
    step(2);
    check_eq("mrst_rx_start", 32'(rx_start), 32'd0);
    check_eq("mrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("mrst_m_data", 32'(m_data), 32'd0);
    check_eq("mrst_level", 32'(fifo_level), 32'd0);
    check_eq("mrst_frame_cnt", 32'(frame_err_cnt), 32'd0);
    rx_line = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(4);
    start_frame("after");
    step(2);
    deliver(8'h3C);
    check_eq("after_m_valid", 32'(m_valid), 32'd1);
    check_eq("after_m_data", 32'(m_data), 32'h3C);
    check_eq("after_level", 32'(fifo_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
